// File: rtl/conv_window_sequencer.sv
// Frame sequencer for the convolver window chain: forwards each accepted pixel as a one-cycle shift and flags stride-aligned KxK windows.
// Shift one cycle after accept, window one cycle later; the stream stalls while a window is unconsumed or about to load.
module conv_window_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int KERNEL_SIZE  = 3,
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28,
    parameter int STRIDE       = 1
) (
    input  logic                            clock,
    input  logic                            r_reset,
    input  logic                            start,
    input  logic [DATA_WIDTH-1:0]           pixel_in,
    input  logic                            pixel_valid,
    output logic                            pixel_ready,
    output logic                            shift_enable,
    output logic [DATA_WIDTH-1:0]           shift_data,
    output logic                            window_valid,
    input  logic                            conv_ready,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] row_count,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  col_count,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_EDGE = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] COL_EDGE = CW'(KERNEL_SIZE - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic          win_pend;
    logic [PW-1:0] row_ph;
    logic [PW-1:0] col_ph;
    logic          accept;
    logic          hit;
    logic          col_wrap;
    logic          row_wrap;
    logic          win_load;
    logic          win_stall;

    // Phases hold (pos - (K-1)) mod STRIDE, so no divider is needed for the hit test.
    assign win_load    = shift_enable && win_pend;
    assign win_stall   = window_valid && !conv_ready;
    assign pixel_ready = (state == STREAM) && !win_load && !win_stall;
    assign accept      = pixel_valid && pixel_ready;
    assign col_wrap    = (col_count == COL_LAST);
    assign row_wrap    = (row_count == ROW_LAST);
    assign hit         = (row_count >= ROW_EDGE) && (col_count >= COL_EDGE)
                         && (row_ph == '0) && (col_ph == '0);

    always_ff @(posedge clock or negedge r_reset) begin
        if (!r_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (accept && col_wrap && row_wrap) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Last shift must land and any window must be taken before the frame closes.
                if (!shift_enable && (!window_valid || conv_ready)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge r_reset) begin
        if (!r_reset) begin
            shift_enable <= 1'b0;
            shift_data   <= '0;
            win_pend     <= 1'b0;
            window_valid <= 1'b0;
            row_count    <= '0;
            col_count    <= '0;
            row_ph       <= '0;
            col_ph       <= '0;
        end else begin
            shift_enable <= accept;
            win_pend     <= accept && hit;
            if (accept) begin
                shift_data <= pixel_in;
            end

            if (win_load) begin
                window_valid <= 1'b1;
            end else if (conv_ready) begin
                window_valid <= 1'b0;
            end

            if (((state == IDLE) && start) || (state == DONE)) begin
                row_count <= '0;
                col_count <= '0;
                row_ph    <= '0;
                col_ph    <= '0;
            end else if (accept) begin
                if (col_wrap) begin
                    col_count <= '0;
                    col_ph    <= '0;
                    row_count <= row_wrap ? '0 : row_count + 1'b1;
                    if (row_wrap || (row_count < ROW_EDGE) || (row_ph == PH_LAST)) begin
                        row_ph <= '0;
                    end else begin
                        row_ph <= row_ph + 1'b1;
                    end
                end else begin
                    col_count <= col_count + 1'b1;
                    if ((col_count < COL_EDGE) || (col_ph == PH_LAST)) begin
                        col_ph <= '0;
                    end else begin
                        col_ph <= col_ph + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized bench for conv_window_sequencer: two 5x5 K=3 instances (stride 1 and 2) checked against an arithmetic window/position model.
module tb_conv_window_sequencer;

    localparam int DW   = 16;
    localparam int K    = 3;
    localparam int W    = 5;
    localparam int H    = 5;
    localparam int NPIX = W * H;

    logic          clock = 1'b0;
    logic          r_reset;
    logic          start;
    logic          sel;
    logic          start_a, start_b;
    logic [DW-1:0] pixel_in;
    logic          pixel_valid;
    logic          conv_ready;

    logic          a_pixel_ready, a_shift_enable, a_window_valid, a_busy, a_frame_done;
    logic [DW-1:0] a_shift_data;
    logic [2:0]    a_row_count, a_col_count;
    logic          b_pixel_ready, b_shift_enable, b_window_valid, b_busy, b_frame_done;
    logic [DW-1:0] b_shift_data;
    logic [2:0]    b_row_count, b_col_count;

    logic          m_pixel_ready, m_shift_enable, m_window_valid, m_busy, m_frame_done;
    logic [DW-1:0] m_shift_data;
    logic [2:0]    m_row_count, m_col_count;

    int total = 0;
    int bad   = 0;
    int src[NPIX];

    always #5 clock = ~clock;

    assign start_a = start && !sel;
    assign start_b = start && sel;

    conv_window_sequencer #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .STRIDE(1)
    ) u_s1 (
        .clock(clock), .r_reset(r_reset), .start(start_a),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(a_pixel_ready),
        .shift_enable(a_shift_enable), .shift_data(a_shift_data),
        .window_valid(a_window_valid), .conv_ready(conv_ready),
        .row_count(a_row_count), .col_count(a_col_count),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    conv_window_sequencer #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .STRIDE(2)
    ) u_s2 (
        .clock(clock), .r_reset(r_reset), .start(start_b),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(b_pixel_ready),
        .shift_enable(b_shift_enable), .shift_data(b_shift_data),
        .window_valid(b_window_valid), .conv_ready(conv_ready),
        .row_count(b_row_count), .col_count(b_col_count),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    always_comb begin
        m_pixel_ready  = sel ? b_pixel_ready  : a_pixel_ready;
        m_shift_enable = sel ? b_shift_enable : a_shift_enable;
        m_window_valid = sel ? b_window_valid : a_window_valid;
        m_busy         = sel ? b_busy         : a_busy;
        m_frame_done   = sel ? b_frame_done   : a_frame_done;
        m_shift_data   = sel ? b_shift_data   : a_shift_data;
        m_row_count    = sel ? b_row_count    : a_row_count;
        m_col_count    = sel ? b_col_count    : a_col_count;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic bit is_hit(input int n, input int s);
        int r, c;
        r = n / W;
        c = n % W;
        return (r >= K - 1) && (c >= K - 1) && ((r - K + 1) % s == 0) && ((c - K + 1) % s == 0);
    endfunction

    // One full frame on the selected instance; vprob/rprob are percent chances of pixel_valid/conv_ready.
    task automatic run_frame(input int vprob, input int rprob, input bit hold, input bit ign);
        int  hits[$];
        int  stride, exp_win, acc, shifted, nwin, consumed, wv_cycles, hold_cnt, cyc;
        bit  prev_wv, prev_cr, prev_se, done, drain_kicked, hold_now, new_win;
        stride = sel ? 2 : 1;
        exp_win = ((H - K) / stride + 1) * ((W - K) / stride + 1);
        for (int n = 0; n < NPIX; n++) begin
            if (is_hit(n, stride)) hits.push_back(n);
            src[n] = int'($urandom() & 32'hFFFF);
        end
        acc = 0; shifted = 0; nwin = 0; consumed = 0; wv_cycles = 0; hold_cnt = 0; cyc = 0;
        prev_wv = 0; prev_cr = 0; prev_se = 0; done = 0; drain_kicked = 0;

        @(posedge clock); #1;
        start = 1'b1; pixel_valid = 1'b0; conv_ready = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check("busy_start", 32'(m_busy), 1);
        check("rdy_start", 32'(m_pixel_ready), 1);

        while (!done && cyc < 1000) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (ign && cyc == 6) start = 1'b1;
            if (ign && acc == NPIX && !drain_kicked && m_busy && !m_frame_done) begin
                start = 1'b1;
                drain_kicked = 1'b1;
            end
            pixel_valid = (acc < NPIX) && (int'($urandom_range(99)) < vprob);
            pixel_in    = (acc < NPIX) ? DW'(src[acc]) : '0;
            conv_ready  = int'($urandom_range(99)) < rprob;
            hold_now    = 1'b0;
            if (hold && m_window_valid && hold_cnt < 6) begin
                conv_ready = 1'b0;
                hold_cnt++;
                hold_now = 1'b1;
            end

            @(negedge clock);
            cyc++;
            if (hold_now) begin
                check("hold_wv", 32'(m_window_valid), 1);
                check("hold_rdy", 32'(m_pixel_ready), 0);
                check("hold_se", 32'(m_shift_enable), 0);
            end
            new_win = m_window_valid && !(prev_wv && !prev_cr);
            if (new_win) begin
                check("win_lat", 32'(prev_se), 1);
                check("win_pos", 32'(shifted - 1), (nwin < hits.size()) ? 32'(hits[nwin]) : 32'hFFFF_FFFF);
                nwin++;
            end
            if (m_shift_enable) begin
                check("order", 32'(m_shift_data), (shifted < NPIX) ? 32'(src[shifted]) : 32'hFFFF_FFFF);
                shifted++;
            end
            if (m_window_valid) begin
                wv_cycles++;
                if (conv_ready) consumed++;
            end
            if (pixel_valid && m_pixel_ready) begin
                check("row", 32'(m_row_count), 32'(acc / W));
                check("col", 32'(m_col_count), 32'(acc % W));
                acc++;
            end
            if (m_frame_done) begin
                done = 1'b1;
                check("frame_pixels", 32'(shifted), NPIX);
                check("frame_windows", 32'(consumed), 32'(exp_win));
                check("frame_hits", 32'(nwin), 32'(hits.size()));
                if (rprob == 100 && !hold) check("wv_cycles", 32'(wv_cycles), 32'(exp_win));
            end
            prev_wv = m_window_valid;
            prev_cr = conv_ready;
            prev_se = m_shift_enable;
        end
        if (!done) check("frame_timeout", 0, 1);

        start = 1'b0;
        pixel_valid = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check("busy_end", 32'(m_busy), 0);
        check("done_once", 32'(m_frame_done), 0);
        check("row_end", 32'(m_row_count), 0);
        check("col_end", 32'(m_col_count), 0);
        check("wv_end", 32'(m_window_valid), 0);
        if (ign) begin
            repeat (3) @(negedge clock);
            check("idle_stay", 32'(m_busy), 0);
        end
    endtask

    task automatic reset_mid_frame();
        int acc, cyc, fd;
        acc = 0; cyc = 0; fd = 0;
        for (int n = 0; n < NPIX; n++) src[n] = int'($urandom() & 32'hFFFF);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (acc < 10 && cyc < 200) begin
            @(posedge clock); #1;
            pixel_valid = 1'b1;
            pixel_in    = DW'(src[acc]);
            conv_ready  = 1'b1;
            @(negedge clock);
            cyc++;
            if (m_frame_done) fd++;
            if (pixel_valid && m_pixel_ready) acc++;
        end
        if (acc < 10) check("rst_timeout", 0, 1);
        @(posedge clock); #3;
        r_reset = 1'b0;
        #1;
        check("rst_busy", 32'(m_busy), 0);
        check("rst_rdy", 32'(m_pixel_ready), 0);
        check("rst_se", 32'(m_shift_enable), 0);
        check("rst_wv", 32'(m_window_valid), 0);
        check("rst_done", 32'(m_frame_done), 0);
        check("rst_data", 32'(m_shift_data), 0);
        check("rst_row", 32'(m_row_count), 0);
        check("rst_col", 32'(m_col_count), 0);
        pixel_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 r_reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (m_frame_done) fd++;
        end
        check("rst_idle", 32'(m_busy), 0);
        check("rst_nodone", 32'(fd), 0);
    endtask

    initial begin
        r_reset = 1'b0; start = 1'b0; sel = 1'b0;
        pixel_valid = 1'b0; conv_ready = 1'b0; pixel_in = '0;
        #12;
        check("reset_busy", 32'(a_busy), 0);
        check("reset_rdy", 32'(a_pixel_ready), 0);
        check("reset_se", 32'(a_shift_enable), 0);
        check("reset_wv", 32'(b_window_valid), 0);
        check("reset_row", 32'(b_row_count), 0);
        #11 r_reset = 1'b1;

        sel = 1'b0; run_frame(100, 100, 1'b0, 1'b0);
        sel = 1'b1; run_frame(100, 100, 1'b0, 1'b0);
        sel = 1'b0; run_frame(100, 100, 1'b1, 1'b0);
        run_frame(50, 50, 1'b0, 1'b0);
        run_frame(50, 50, 1'b0, 1'b0);
        sel = 1'b1; run_frame(50, 50, 1'b0, 1'b0);
        sel = 1'b0; run_frame(100, 100, 1'b0, 1'b1);
        sel = 1'b1; run_frame(100, 100, 1'b0, 1'b1);
        sel = 1'b0; reset_mid_frame();
        run_frame(70, 60, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
